// File: rtl/sram_master_pkg.sv
// Shared types and constants for the SRAM initiator: FSM states,
// phase-counter width helper and the word-alignment mask.
package sram_master_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SETUP  = 3'd1,
      STROBE = 3'd2,
      HOLD   = 3'd3,
      RESP   = 3'd4
   } state_t;

   localparam logic [1:0] ALIGN_MASK = 2'b11;

   // Wide enough to hold (longest phase - 1), plus a spare bit.
   function automatic int phase_cnt_w(input int setup_cyc, input int strobe_cyc, input int hold_cyc);
      int m;
      m = setup_cyc;
      if (strobe_cyc > m) m = strobe_cyc;
      if (hold_cyc > m) m = hold_cyc;
      return $clog2(m) + 1;
   endfunction

endpackage

// File: rtl/sram_phase_timer.sv
// Down-counter shared by the setup, strobe and hold phases.
// Loads (phase length - 1) on entry; done while the count is zero, no wrap.
module sram_phase_timer #(
   parameter int W = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         done
);

   logic [W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (cnt != '0) begin
         cnt <= cnt - W'(1);
      end
   end

   assign done = (cnt == '0);

endmodule

// File: rtl/sram_master.sv
// Single-word valid/ready initiator for the asynchronous SRAM model with
// programmable setup/strobe/hold phases and a held response.
module sram_master
   import sram_master_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int SETUP_CYC  = 1,
   parameter int STROBE_CYC = 2,
   parameter int HOLD_CYC   = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              sram_cs,
   output logic              sram_oe,
   output logic              sram_we,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [DATA_W-1:0] sram_din,
   input  logic [DATA_W-1:0] sram_dout
);

   localparam int CW = phase_cnt_w(SETUP_CYC, STROBE_CYC, HOLD_CYC);
   localparam logic [CW-1:0] SETUP_LD  = CW'(SETUP_CYC - 1);
   localparam logic [CW-1:0] STROBE_LD = CW'(STROBE_CYC - 1);
   localparam logic [CW-1:0] HOLD_LD   = CW'((HOLD_CYC > 0) ? HOLD_CYC - 1 : 0);

   state_t          state;
   logic            ready_q;
   logic            is_write;
   logic            accept;
   logic            misaligned;
   logic            load;
   logic [CW-1:0]   load_val;
   logic            done;

   assign req_ready  = ready_q;
   assign accept     = (state == IDLE) && req_valid && ready_q;
   assign misaligned = (req_addr[1:0] & ALIGN_MASK) != 2'b00;

   always_comb begin
      load     = 1'b0;
      load_val = '0;
      case (state)
         IDLE: begin
            if (accept && !misaligned) begin
               load     = 1'b1;
               load_val = SETUP_LD;
            end
         end
         SETUP: begin
            if (done) begin
               load     = 1'b1;
               load_val = STROBE_LD;
            end
         end
         STROBE: begin
            if (done && (HOLD_CYC > 0)) begin
               load     = 1'b1;
               load_val = HOLD_LD;
            end
         end
         default: ;
      endcase
   end

   sram_phase_timer #(.W(CW)) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (load),
      .load_val (load_val),
      .done     (done)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         ready_q   <= 1'b0;
         is_write  <= 1'b0;
         sram_cs   <= 1'b0;
         sram_oe   <= 1'b0;
         sram_we   <= 1'b0;
         sram_addr <= '0;
         sram_din  <= '0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               ready_q <= 1'b1;
               if (accept) begin
                  ready_q  <= 1'b0;
                  is_write <= req_we;
                  if (misaligned) begin
                     // No bus cycle: answer straight away, SRAM pins untouched.
                     state     <= RESP;
                     rsp_valid <= 1'b1;
                     rsp_err   <= 1'b1;
                     rsp_rdata <= '0;
                  end else begin
                     state     <= SETUP;
                     sram_cs   <= 1'b1;
                     sram_addr <= req_addr;
                     if (req_we) sram_din <= req_wdata;
                  end
               end
            end
            SETUP: begin
               if (done) begin
                  state   <= STROBE;
                  sram_oe <= ~is_write;
                  sram_we <= is_write;
               end
            end
            STROBE: begin
               if (done) begin
                  sram_oe   <= 1'b0;
                  sram_we   <= 1'b0;
                  rsp_rdata <= is_write ? '0 : sram_dout;
                  if (HOLD_CYC == 0) begin
                     state     <= RESP;
                     sram_cs   <= 1'b0;
                     rsp_valid <= 1'b1;
                     rsp_err   <= 1'b0;
                  end else begin
                     state <= HOLD;
                  end
               end
            end
            HOLD: begin
               if (done) begin
                  state     <= RESP;
                  sram_cs   <= 1'b0;
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b0;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  state     <= IDLE;
                  rsp_valid <= 1'b0;
                  ready_q   <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sram_master.sv
// Bench for sram_master: default-timing instance plus a 1/1/0 timing instance
// sharing one behavioural SRAM, checked against an array reference model.
module tb_sram_master;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        sel = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_we = 1'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        rsp_ready = 1'b0;

   logic        rdy0, rdy1, rv0, rv1, err0, err1;
   logic [31:0] rd0, rd1;
   logic        cs0, cs1, oe0, oe1, we0, we1;
   logic [31:0] a0, a1, d0, d1;
   logic [31:0] sram_dout;

   logic        req_ready, rsp_valid, rsp_err;
   logic [31:0] rsp_rdata;
   logic        bus_cs, bus_oe, bus_we;
   logic [31:0] bus_addr, bus_din;

   always #5 clk = ~clk;

   sram_master u0 (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid & ~sel), .req_ready(rdy0),
      .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rv0), .rsp_ready(rsp_ready & ~sel), .rsp_rdata(rd0), .rsp_err(err0),
      .sram_cs(cs0), .sram_oe(oe0), .sram_we(we0), .sram_addr(a0), .sram_din(d0),
      .sram_dout(sram_dout)
   );

   sram_master #(.SETUP_CYC(1), .STROBE_CYC(1), .HOLD_CYC(0)) u1 (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid & sel), .req_ready(rdy1),
      .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rv1), .rsp_ready(rsp_ready & sel), .rsp_rdata(rd1), .rsp_err(err1),
      .sram_cs(cs1), .sram_oe(oe1), .sram_we(we1), .sram_addr(a1), .sram_din(d1),
      .sram_dout(sram_dout)
   );

   assign req_ready = sel ? rdy1 : rdy0;
   assign rsp_valid = sel ? rv1  : rv0;
   assign rsp_rdata = sel ? rd1  : rd0;
   assign rsp_err   = sel ? err1 : err0;
   assign bus_cs    = sel ? cs1  : cs0;
   assign bus_oe    = sel ? oe1  : oe0;
   assign bus_we    = sel ? we1  : we0;
   assign bus_addr  = sel ? a1   : a0;
   assign bus_din   = sel ? d1   : d0;

   // Behavioural SRAM: combinational read while cs&oe, write while cs&we.
   logic [31:0] mem [64];
   assign sram_dout = (bus_cs && bus_oe) ? mem[bus_addr[7:2]] : 32'h0;
   always @(posedge clk) if (bus_cs && bus_we) mem[bus_addr[7:2]] <= bus_din;

   // Reference contents, updated only from the requests the bench issues.
   logic [31:0] model [64];

   // Bus monitor, sampled mid-cycle; running totals only.
   int oe_rise = 0, we_rise = 0, oe_cyc = 0, cs_cyc = 0, overlap = 0, addr_chg = 0;
   logic p_cs = 1'b0, p_oe = 1'b0, p_we = 1'b0;
   logic [31:0] p_addr = '0;
   always @(posedge clk) begin
      #1;
      if (bus_oe && !p_oe) oe_rise++;
      if (bus_we && !p_we) we_rise++;
      if (bus_oe) oe_cyc++;
      if (bus_cs) cs_cyc++;
      if (bus_oe && bus_we) overlap++;
      if (bus_cs && p_cs && bus_addr != p_addr) addr_chg++;
      p_cs = bus_cs; p_oe = bus_oe; p_we = bus_we; p_addr = bus_addr;
   end

   int tests = 0, fails = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input int bp, output logic [31:0] rdata, output logic err, output int lat);
      int n;
      @(negedge clk);
      req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
      rsp_ready = (bp == 0);
      n = 0;
      while (!req_ready && n < 50) begin @(negedge clk); n++; end
      if (!req_ready) check("req_ready_timeout", 32'd0, 32'd1);
      @(negedge clk);
      req_valid = 1'b0;
      lat = 1;
      while (!rsp_valid && lat < 50) begin @(negedge clk); lat++; end
      if (!rsp_valid) check("rsp_timeout", 32'd0, 32'd1);
      rdata = rsp_rdata; err = rsp_err;
      for (int i = 0; i < bp; i++) begin
         @(negedge clk);
         check("bp_valid", rsp_valid, 1);
         check("bp_rdata", rsp_rdata, rdata);
         check("bp_req_ready", req_ready, 0);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      check("rsp_consumed", rsp_valid, 0);
      check("ready_after_rsp", req_ready, 1);
      rsp_ready = 1'b0;
   endtask

   // Full transaction check against the reference model and the phase timing.
   task automatic run_checked(input string tag, input logic we, input logic [31:0] addr,
                              input logic [31:0] wdata, input int bp,
                              input int s, input int st, input int h);
      logic [31:0] rdata, exp_rdata;
      logic err, exp_err;
      int lat, exp_lat, o_r, w_r, o_c, c_c;
      exp_err   = (addr[1:0] != 2'b00);
      exp_rdata = we ? 32'h0 : model[addr[7:2]];
      exp_lat   = exp_err ? 1 : s + st + h + 1;
      o_r = oe_rise; w_r = we_rise; o_c = oe_cyc; c_c = cs_cyc;
      access(we, addr, wdata, bp, rdata, err, lat);
      check({tag, "_err"}, err, exp_err);
      check({tag, "_lat"}, lat, exp_lat);
      if (!exp_err) check({tag, "_rdata"}, rdata, exp_rdata);
      check({tag, "_oe_rises"}, oe_rise - o_r, (!exp_err && !we) ? 1 : 0);
      check({tag, "_we_rises"}, we_rise - w_r, (!exp_err && we) ? 1 : 0);
      check({tag, "_oe_cycles"}, oe_cyc - o_c, (!exp_err && !we) ? st : 0);
      check({tag, "_cs_cycles"}, cs_cyc - c_c, exp_err ? 0 : s + st + h);
      if (we && !exp_err) model[addr[7:2]] = wdata;
   endtask

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_err;
      int          exp_lat;
   } vec_t;

   initial begin
      vec_t tbl [5];
      logic [31:0] rdata, a, w;
      logic err;
      int lat, cnt;

      for (int i = 0; i < 64; i++) begin
         w = $urandom;
         mem[i] = w; model[i] = w;
      end
      mem[4] = 32'h1234ABCD; model[4] = 32'h1234ABCD;

      tbl[0] = '{1'b0, 32'h10, 32'h0,        32'h1234ABCD, 1'b0, 5};
      tbl[1] = '{1'b1, 32'h10, 32'hDEADBEEF, 32'h0,        1'b0, 5};
      tbl[2] = '{1'b0, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0, 5};
      tbl[3] = '{1'b0, 32'h12, 32'h0,        32'h0,        1'b1, 1};
      tbl[4] = '{1'b1, 32'h13, 32'h55AA55AA, 32'h0,        1'b1, 1};

      // Reset state
      #12;
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_rdata", rsp_rdata, 0);
      check("rst_rsp_err", rsp_err, 0);
      check("rst_cs_oe_we", {bus_cs, bus_oe, bus_we}, 0);
      check("rst_addr", bus_addr, 0);
      check("rst_din", bus_din, 0);
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);
      check("rst_req_ready", req_ready, 1);

      // Directed vectors from the table
      for (int i = 0; i < 5; i++) begin
         int o_r, w_r, o_c, c_c;
         o_r = oe_rise; w_r = we_rise; o_c = oe_cyc; c_c = cs_cyc;
         access(tbl[i].we, tbl[i].addr, tbl[i].wdata, 0, rdata, err, lat);
         check($sformatf("vec%0d_err", i), err, tbl[i].exp_err);
         check($sformatf("vec%0d_lat", i), lat, tbl[i].exp_lat);
         if (!tbl[i].exp_err) check($sformatf("vec%0d_rdata", i), rdata, tbl[i].exp_rdata);
         check($sformatf("vec%0d_oe_cycles", i), oe_cyc - o_c, (!tbl[i].exp_err && !tbl[i].we) ? 2 : 0);
         check($sformatf("vec%0d_we_rises", i), we_rise - w_r, (!tbl[i].exp_err && tbl[i].we) ? 1 : 0);
         check($sformatf("vec%0d_oe_rises", i), oe_rise - o_r, (!tbl[i].exp_err && !tbl[i].we) ? 1 : 0);
         check($sformatf("vec%0d_cs_cycles", i), cs_cyc - c_c, tbl[i].exp_err ? 0 : 4);
         if (tbl[i].we && !tbl[i].exp_err) model[tbl[i].addr[7:2]] = tbl[i].wdata;
      end

      // Randomized traffic against the reference model
      for (int i = 0; i < 30; i++) begin
         a = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
         if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
         run_checked("rand", 1'($urandom_range(0, 1)), a, $urandom, $urandom_range(0, 2), 1, 2, 1);
      end

      // Backpressure: response held for 4 cycles
      run_checked("bp", 1'b0, 32'h10, 32'h0, 4, 1, 2, 1);

      // Reset during the strobe of a write
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'hCAFEF00D;
      cnt = 0;
      while (!req_ready && cnt < 50) begin @(negedge clk); cnt++; end
      @(negedge clk); req_valid = 1'b0;
      @(negedge clk);
      check("mid_we_high", bus_we, 1);
      #2 rst_n = 1'b0;
      #1;
      check("mid_cs_drop", bus_cs, 0);
      check("mid_we_drop", bus_we, 0);
      @(negedge clk); rst_n = 1'b1;
      cnt = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (rsp_valid) cnt++;
      end
      check("mid_no_rsp", cnt, 0);
      check("mid_req_ready", req_ready, 1);
      run_checked("post_rst", 1'b0, 32'h10, 32'h0, 0, 1, 2, 1);

      // Shortest timing: setup 1, strobe 1, hold 0
      sel = 1'b1;
      run_checked("sweep_w", 1'b1, 32'h30, 32'hA5A5_0F0F, 0, 1, 1, 0);
      run_checked("sweep_r", 1'b0, 32'h30, 32'h0, 0, 1, 1, 0);
      run_checked("sweep_r10", 1'b0, 32'h10, 32'h0, 1, 1, 1, 0);
      run_checked("sweep_mis", 1'b0, 32'h31, 32'h0, 0, 1, 1, 0);

      check("oe_we_overlap", overlap, 0);
      check("addr_change_under_cs", addr_chg, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/sram_master.md
Name: sram_master

Overview:
- Clocked initiator for the asynchronous word-addressed SRAM model (cs/oe/we/addr/din/dout).
- Accepts single-word read/write requests from a datapath or testbench over a valid/ready handshake.
- Sequences the SRAM control strobes with programmable setup, strobe and hold phases, captures read data and returns a held response.
- Sits between the processor memory stage and the SRAM.

Parameters:
- ADDR_W, 32, address width; sram_addr is driven unchanged from req_addr.
- DATA_W, 32, data width.
- SETUP_CYC, 1, cycles with cs=1 and address/data stable before the strobe. Must be >=1.
- STROBE_CYC, 2, cycles oe or we is held high. Must be >=1.
- HOLD_CYC, 1, cycles with cs=1 and address/data stable after the strobe drops. Must be >=0.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  master can accept a request; high only in IDLE.
- req_we  in  1  1=write, 0=read.
- req_addr  in  ADDR_W  byte address; must be word aligned.
- req_wdata  in  DATA_W  write data.
- rsp_valid  out  1  response available; held until accepted.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  DATA_W  read data; 0 for writes.
- rsp_err  out  1  misaligned request.
- sram_cs  out  1  chip select.
- sram_oe  out  1  output enable (read strobe).
- sram_we  out  1  write enable (write strobe).
- sram_addr  out  ADDR_W  SRAM address.
- sram_din  out  DATA_W  data to the SRAM.
- sram_dout  in  DATA_W  data from the SRAM.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - State goes to IDLE.
  - All sram_* outputs, rsp_valid, rsp_rdata, rsp_err and the phase counter go to 0.
  - req_ready goes to 1 once rst_n is released.
- Reset asserted mid-transfer: strobes drop immediately, the transaction is discarded and no response is issued.
- States: IDLE, SETUP, STROBE, HOLD, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&req_ready, latch we/addr/wdata.
  - If req_addr[1:0]!=0: go to RESP with rsp_err=1. No SRAM cycle occurs; cs stays 0.
  - Otherwise go to SETUP.
- SETUP:
  - cs=1, addr and din (din only on writes) driven from the latched values; oe=we=0.
  - Lasts exactly SETUP_CYC cycles, then STROBE.
- STROBE:
  - cs=1; oe=1 for reads or we=1 for writes; never both.
  - Lasts STROBE_CYC cycles.
  - On the last strobe cycle of a read, register sram_dout into rsp_rdata.
  - Then go to HOLD, or to RESP if HOLD_CYC=0.
- HOLD: cs=1, oe=we=0, addr/din unchanged; lasts HOLD_CYC cycles, then RESP.
- RESP:
  - cs=0; addr/din keep their last values (no spurious transitions).
  - rsp_valid=1 with rsp_rdata/rsp_err stable.
  - On rsp_ready=1, return to IDLE and clear rsp_valid. rsp_rdata and rsp_err keep their values until the next response.
- rsp_ready may already be high on the first RESP cycle; the response then lasts one cycle.
- sram_addr/sram_din may change only in IDLE→SETUP.
- Exactly one rising edge of oe or we per access. The SRAM model acts on every control or address change, so this rule is mandatory.
- Latency from accept to rsp_valid: SETUP_CYC+STROBE_CYC+HOLD_CYC+1 cycles (defaults: 5).
- Back-to-back throughput: one access per latency+1 cycles when rsp_ready is tied high.
- req_valid while not in IDLE is ignored; the requester must hold it.
- Phase counter:
  - Width is clog2 of the maximum of the phase lengths, plus 1.
  - Loads phase length minus 1 on entry to a phase and counts down.
  - Phase transition on counter == 0. No wrap.

Decomposition:
- Package sram_master_pkg holds:
  - the state enum (IDLE, SETUP, STROBE, HOLD, RESP);
  - a width function for the phase counter;
  - the alignment-mask constant.
- Optional sub-module sram_phase_timer: load/count-down/done counter shared by the three timed phases.
- Bench instantiates the existing SRAM model as the responder.

Test Plan:
- Read: SRAM preloaded 0x00000010/0x1234ABCD; read addr 0x10 with defaults.
  - rsp_valid exactly 5 cycles after accept; rsp_rdata=0x1234ABCD; rsp_err=0.
  - oe high for exactly 2 cycles and never overlaps we.
- Write then read: write 0x10←0xDEADBEEF, then read 0x10.
  - Write response has rsp_rdata=0; read returns 0xDEADBEEF.
  - we has exactly one rising edge.
- Misaligned: read 0x12.
  - rsp_valid after 1 cycle with rsp_err=1.
  - sram_cs/oe/we never asserted.
- Backpressure: hold rsp_ready=0 for 4 cycles during a read of 0x10.
  - rsp_valid and rsp_rdata stay stable; req_ready stays 0.
  - Accept occurs on the cycle rsp_ready=1.
- Reset mid-strobe: assert rst_n=0 during the STROBE phase of a write.
  - cs/we drop to 0 asynchronously and no response is issued.
  - After release, req_ready=1 and a following read of 0x10 completes normally.
- Parameter sweep: SETUP=1, STROBE=1, HOLD=0.
  - Latency 3; rsp_rdata correct.
  - Address stable on every cycle where cs=1.
